// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter unit.
// FSM states, mtvec mode encodings and the base instruction size.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    localparam int INSN_BYTES = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap > mret > stall > jump > seq.
// Ports: run qualifies updates; redirect requests and targets in;
// pc_next and mis_det (jump taken to a misaligned target) out.
// Macro PC_UNIT_COMPRESSED_EN relaxes alignment to 2 bytes and
// selects a 2- or 4-byte increment from instr_lo.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            run,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] alu_out,
    input  logic            trap_req,
    input  logic            trap_is_irq,
    input  logic [4:0]      trap_cause,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic [1:0]      instr_lo,
    input  logic [XLEN-1:0] count,
    output logic [XLEN-1:0] pc_next,
    output logic            mis_det
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] trap_tgt;
    logic [XLEN-1:0] mret_tgt;
    logic [XLEN-1:0] seq_inc;
    logic            tgt_bad;
    logic            unused_bits;

    assign base = {mtvec[XLEN-1:2], 2'b00};

    // Only interrupts are spread across the vector table.
    always_comb begin
        trap_tgt = base;
        unique case (mtvec[1:0])
            MTVEC_MODE_VECTORED: begin
                if (trap_is_irq)
                    trap_tgt = base + XLEN'({trap_cause, 2'b00});
            end
            MTVEC_MODE_DIRECT: trap_tgt = base;
            default:           trap_tgt = base;
        endcase
    end

`ifdef PC_UNIT_COMPRESSED_EN
    assign mret_tgt = {mepc[XLEN-1:1], 1'b0};
    assign tgt_bad  = alu_out[0];
    assign seq_inc  = (instr_lo != 2'b11) ? XLEN'(2)
                                          : XLEN'(INSN_BYTES);
`else
    assign mret_tgt = {mepc[XLEN-1:2], 2'b00};
    assign tgt_bad  = |alu_out[1:0];
    assign seq_inc  = XLEN'(INSN_BYTES);
`endif

    assign unused_bits = ^{instr_lo, mepc[1:0]};

    always_comb begin
        pc_next = count;
        mis_det = 1'b0;
        priority case (1'b1)
            !run:     pc_next = count;
            trap_req: pc_next = trap_tgt;
            mret:     pc_next = mret_tgt;
            stall:    pc_next = count;
            pc_sel: begin
                // A bad target is dropped, not truncated.
                if (tgt_bad) begin
                    pc_next = count;
                    mis_det = 1'b1;
                end else begin
                    pc_next = alu_out;
                end
            end
            default:  pc_next = count + seq_inc;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with boot/run/halt FSM and prioritised redirects.
// In: cpu_clk, reset (async, high), stall, pc_sel/alu_out, trap_req,
//   trap_is_irq, trap_cause, mtvec, mret/mepc, halt_req, resume,
//   instr_lo. Out: count, pc_next, pc_prev, pc_valid, misaligned,
//   halted. Optional macro: PC_UNIT_COMPRESSED_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(32'h8000_0000),
    parameter int              BOOT_CYCLES = 2
) (
    input  logic            cpu_clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_sel,
    input  logic [XLEN-1:0] alu_out,
    input  logic            trap_req,
    input  logic            trap_is_irq,
    input  logic [4:0]      trap_cause,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret,
    input  logic [XLEN-1:0] mepc,
    input  logic            halt_req,
    input  logic            resume,
    input  logic [1:0]      instr_lo,
    output logic [XLEN-1:0] count,
    output logic [XLEN-1:0] pc_next,
    output logic [XLEN-1:0] pc_prev,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            halted
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    pc_state_e  state;
    logic [3:0] boot_cnt;
    logic       mis_det;
    logic       run;

    assign run = (state == RUN);

    pc_next_sel #(
        .XLEN(XLEN)
    ) u_sel (
        .run        (run),
        .stall      (stall),
        .pc_sel     (pc_sel),
        .alu_out    (alu_out),
        .trap_req   (trap_req),
        .trap_is_irq(trap_is_irq),
        .trap_cause (trap_cause),
        .mtvec      (mtvec),
        .mret       (mret),
        .mepc       (mepc),
        .instr_lo   (instr_lo),
        .count      (count),
        .pc_next    (pc_next),
        .mis_det    (mis_det)
    );

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            count      <= RESET_VEC;
            pc_prev    <= RESET_VEC;
            misaligned <= 1'b0;
        end else begin
            if (pc_next != count) begin
                pc_prev <= count;
                count   <= pc_next;
            end
            misaligned <= mis_det;
        end
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            boot_cnt <= 4'd0;
            pc_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                HALT: begin
                    // resume beats a concurrent halt_req
                    if (resume) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    boot_cnt <= 4'd0;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios pinned to
// literal values, then randomized traffic against a reference model.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h8000_0000;
    localparam int BOOTC = 2;

    logic        cpu_clk = 1'b0;
    logic        reset;
    logic        stall, pc_sel, trap_req, trap_is_irq;
    logic        mret, halt_req, resume;
    logic [31:0] alu_out, mtvec, mepc;
    logic [4:0]  trap_cause;
    logic [1:0]  instr_lo;
    logic [31:0] count, pc_next, pc_prev;
    logic        pc_valid, misaligned, halted;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] m_count, m_prev;
    int          m_mode;
    int          m_boot_left;
    bit          m_mis;

    always #5 cpu_clk = ~cpu_clk;

    pc_unit #(
        .XLEN(32), .RESET_VEC(RV), .BOOT_CYCLES(BOOTC)
    ) dut (
        .cpu_clk(cpu_clk), .reset(reset), .stall(stall),
        .pc_sel(pc_sel), .alu_out(alu_out), .trap_req(trap_req),
        .trap_is_irq(trap_is_irq), .trap_cause(trap_cause),
        .mtvec(mtvec), .mret(mret), .mepc(mepc),
        .halt_req(halt_req), .resume(resume), .instr_lo(instr_lo),
        .count(count), .pc_next(pc_next), .pc_prev(pc_prev),
        .pc_valid(pc_valid), .misaligned(misaligned),
        .halted(halted)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // mode: 0 boot, 1 run, 2 halt
    task automatic model_reset();
        m_count     = RV;
        m_prev      = RV;
        m_mode      = 0;
        m_boot_left = BOOTC;
        m_mis       = 0;
    endtask

    function automatic logic [31:0] model_next(output bit bad);
        logic [31:0] t;
        bad = 0;
        if (m_mode != 1) return m_count;
        if (trap_req) begin
            t = mtvec & ~32'd3;
            if (mtvec % 4 == 1 && trap_is_irq)
                t = t + 32'(trap_cause) * 4;
            return t;
        end
`ifdef PC_UNIT_COMPRESSED_EN
        if (mret) return mepc & ~32'd1;
`else
        if (mret) return mepc & ~32'd3;
`endif
        if (stall) return m_count;
        if (pc_sel) begin
`ifdef PC_UNIT_COMPRESSED_EN
            bad = (alu_out % 2) != 0;
`else
            bad = (alu_out % 4) != 0;
`endif
            return bad ? m_count : alu_out;
        end
`ifdef PC_UNIT_COMPRESSED_EN
        return m_count + ((instr_lo == 2'b11) ? 32'd4 : 32'd2);
`else
        return m_count + 32'd4;
`endif
    endfunction

    task automatic model_edge();
        bit bad;
        logic [31:0] nx;
        nx = model_next(bad);
        m_mis = bad;
        if (nx != m_count) begin
            m_prev  = m_count;
            m_count = nx;
        end
        if (m_mode == 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_mode = 1;
        end else if (m_mode == 1) begin
            if (halt_req) m_mode = 2;
        end else begin
            if (resume) m_mode = 1;
        end
    endtask

    task automatic check_outs();
        chk("count", count, m_count);
        chk("pc_prev", pc_prev, m_prev);
        chk("pc_valid", 32'(pc_valid), 32'(m_mode == 1));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("misaligned", 32'(misaligned), 32'(m_mis));
    endtask

    // inputs are driven just after a negedge before calling
    task automatic step();
        bit bad;
        #1;
        chk("pc_next", pc_next, model_next(bad));
        @(posedge cpu_clk);
        model_edge();
        @(negedge cpu_clk);
        check_outs();
    endtask

    task automatic idle();
        stall = 0; pc_sel = 0; alu_out = 0; trap_req = 0;
        trap_is_irq = 0; trap_cause = 0; mtvec = 0; mret = 0;
        mepc = 0; halt_req = 0; resume = 0; instr_lo = 2'b11;
    endtask

    task automatic do_reset();
        #2 reset = 1;
        #1;
        model_reset();
        chk("async_rst_count", count, RV);
        chk("async_rst_prev", pc_prev, RV);
        chk("async_rst_valid", 32'(pc_valid), 0);
        chk("async_rst_mis", 32'(misaligned), 0);
        chk("async_rst_halt", 32'(halted), 0);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        check_outs();
        reset = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        model_reset();
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        chk("rst_count", count, 32'h8000_0000);
        chk("rst_valid", 32'(pc_valid), 0);
        check_outs();
        reset = 0;

        // boot then free-run
        step();
        chk("boot1_valid", 32'(pc_valid), 0);
        step();
        chk("boot2_valid", 32'(pc_valid), 1);
        chk("run0", count, 32'h8000_0000);
        step();
        chk("run1", count, 32'h8000_0004);
        step();
        chk("run2", count, 32'h8000_0008);

        // jump under stall, then released
        pc_sel = 1; alu_out = 32'h8000_0100; stall = 1;
        step();
        chk("stall_hold", count, 32'h8000_0008);
        stall = 0;
        step();
        chk("jump", count, 32'h8000_0100);
        chk("jump_prev", pc_prev, 32'h8000_0008);

        // misaligned target
        alu_out = 32'h8000_0102;
        step();
`ifdef PC_UNIT_COMPRESSED_EN
        chk("mis_tgt", count, 32'h8000_0102);
        chk("mis_pulse", 32'(misaligned), 0);
`else
        chk("mis_hold", count, 32'h8000_0100);
        chk("mis_pulse", 32'(misaligned), 1);
`endif
        idle();
        step();
        chk("mis_clear", 32'(misaligned), 0);

        // vectored interrupt beats stall and jump
        trap_req = 1; trap_is_irq = 1; trap_cause = 7;
        mtvec = 32'h8000_1001; pc_sel = 1; stall = 1;
        alu_out = 32'h8000_0200;
        step();
        chk("trap_vec", count, 32'h8000_101C);

        // halt: update of that cycle still happens
        idle();
        halt_req = 1;
        step();
        chk("halt_upd", count, 32'h8000_1020);
        chk("halt_flag", 32'(halted), 1);
        halt_req = 0;
        for (int i = 0; i < 5; i++) begin
            pc_sel = 1; alu_out = 32'h0000_0040;
            trap_req = (i % 2 == 0); mtvec = 32'h0000_0100;
            step();
            chk("halt_frozen", count, 32'h8000_1020);
        end
        idle();
        resume = 1; halt_req = 1;
        step();
        chk("resume_valid", 32'(pc_valid), 1);
        chk("resume_count", count, 32'h8000_1020);
        idle();
        step();
        chk("resume_inc", count, 32'h8000_1024);

        // wrap at top of address space
        pc_sel = 1; alu_out = 32'hFFFF_FFFC;
        step();
        chk("pre_wrap", count, 32'hFFFF_FFFC);
        idle();
        step();
        chk("wrap", count, 32'h0000_0000);

        // mid-run async reset
        do_reset();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            stall       = ($urandom_range(0, 3) == 0);
            pc_sel      = ($urandom_range(0, 2) == 0);
            alu_out     = $urandom;
            if ($urandom_range(0, 1) == 1) alu_out[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0)
                alu_out = 32'hFFFF_FFF0 | (alu_out & 32'hC);
            trap_req    = ($urandom_range(0, 15) == 0);
            trap_is_irq = 1'($urandom_range(0, 1));
            trap_cause  = 5'($urandom);
            mtvec       = $urandom;
            mret        = ($urandom_range(0, 15) == 0);
            mepc        = $urandom;
            halt_req    = ($urandom_range(0, 19) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            instr_lo    = 2'($urandom);
            if ($urandom_range(0, 249) == 0) do_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the single-cycle program counter; owns the fetch address for the core.
- Adds the following over the previous counter:
  - configurable width and reset vector;
  - stall hold;
  - trap, mret and jump redirect with fixed priority;
  - vectored trap targets and misaligned-target detection;
  - a boot/run/halt state machine that qualifies the fetch address.
- Feeds instruction memory address and the CSR unit (pc_prev for mepc capture).

Parameters:
- XLEN, 32, datapath/address width.
- RESET_VEC, 32'h8000_0000, PC value loaded on reset.
- BOOT_CYCLES, 2, cycles pc_valid stays low after reset release (range 1..15).

Ports:
- cpu_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold PC (sequential and jump updates suppressed).
- pc_sel  in  1  take jump/branch target alu_out.
- alu_out  in  XLEN  jump/branch target.
- trap_req  in  1  exception/interrupt redirect request.
- trap_is_irq  in  1  trap is an interrupt (vectored mode applies).
- trap_cause  in  5  cause code for vectored offset.
- mtvec  in  XLEN  trap vector CSR; bits[1:0] are the mode.
- mret  in  1  return from trap.
- mepc  in  XLEN  return target.
- halt_req  in  1  request halt.
- resume  in  1  leave halt.
- instr_lo  in  2  bits[1:0] of the current instruction; used only with the optional feature.
- count  out  XLEN  current PC.
- pc_next  out  XLEN  value count takes at the next edge if no reset.
- pc_prev  out  XLEN  PC of the previous accepted update.
- pc_valid  out  1  count is a legal fetch address.
- misaligned  out  1  one-cycle pulse: jump target was misaligned.
- halted  out  1  state is HALT.

Behaviour:
- Reset values (immediate, asynchronous):
  - count = pc_prev = RESET_VEC;
  - state = BOOT with boot counter = 0;
  - pc_valid = 0, misaligned = 0, halted = 0.
- States:
  - BOOT: count is held. The boot counter increments each cycle. When the counter reaches BOOT_CYCLES-1, the block moves to RUN on the next edge.
  - RUN: pc_valid = 1.
  - HALT: count is held, pc_valid = 0, halted = 1.
- RUN to HALT: halt_req sampled high. The PC update of that same cycle still occurs.
- HALT to RUN: resume sampled high. In HALT, trap_req, mret and pc_sel are ignored. Simultaneous halt_req and resume while in HALT: resume wins.
- Next-PC priority in RUN, evaluated combinationally into pc_next:
  1. trap_req: target = mtvec base, where base = {mtvec[XLEN-1:2], 2'b00}. If mtvec[1:0] == 2'b01 and trap_is_irq, target = base + (trap_cause << 2). Overrides stall.
  2. mret: target = {mepc[XLEN-1:2], 2'b00}. Overrides stall.
  3. stall: pc_next = count.
  4. pc_sel: target = alu_out, unless it is misaligned (alu_out[1:0] != 0). On a misaligned target, pc_next = count and misaligned pulses on the next cycle.
  5. Otherwise: count + 4.
- pc_prev loads the old count on every edge where count changes.
- All additions wrap modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0, with no flag raised.
- misaligned is registered. It is high for exactly one cycle after the offending edge and is cleared by reset.
- Reset mid-operation aborts any redirect; no partial state survives.

Optional Feature:
- Macro: PC_UNIT_COMPRESSED_EN.
- When defined:
  - sequential increment is 2 if instr_lo != 2'b11, else 4;
  - jump targets are misaligned only when alu_out[0] != 0;
  - mret target = {mepc[XLEN-1:1], 1'b0}.
- When undefined: instr_lo is ignored, the increment is always 4, and the 4-byte alignment rules above apply.

Decomposition:
- Package pc_pkg holds:
  - typedef pc_state_e {BOOT, RUN, HALT};
  - localparams MTVEC_MODE_DIRECT = 2'b00 and MTVEC_MODE_VECTORED = 2'b01;
  - constant INSN_BYTES = 4.
- One natural sub-module: pc_next_sel, a combinational priority mux and target computation. It outputs pc_next and a misaligned-detect signal.
- The top level holds the FSM, boot counter and registers.

Test Plan:
- Reset release, then free-run: pc_valid = 0 for 2 cycles, then count = 8000_0000, 8000_0004, 8000_0008.
- pc_sel = 1 with alu_out = 8000_0100 and stall = 1: count holds. Drop stall: next count = 8000_0100, pc_prev = old PC.
- pc_sel with alu_out = 8000_0102: count holds and misaligned pulses for 1 cycle. With PC_UNIT_COMPRESSED_EN defined, count = 8000_0102.
- trap_req with mtvec = 8000_1001, trap_is_irq = 1, trap_cause = 7, with pc_sel and stall also high: count = 8000_101C.
- halt_req in RUN: halted = 1 and count frozen for 5 cycles despite pc_sel/trap. Then resume: counting continues from the frozen PC + 4.
- count = FFFF_FFFC free-running wraps to 0000_0000. Asserting reset mid-run returns count to 8000_0000 asynchronously.
